// File: rtl/ternary_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ternary_pkg                                                      |
// | Trit type, encodings and helpers shared by ternary blocks.       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_0   = 2'b00;
  localparam trit_t TRIT_1   = 2'b01;
  localparam trit_t TRIT_2   = 2'b10;
  localparam trit_t TRIT_ILL = 2'b11;

  function automatic logic trit_is_legal(input trit_t t);
    return (t != TRIT_ILL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ternary_ripple_inc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ternary_ripple_inc                                               |
// | Combinational N-trit ripple of half adders: count + inc.         |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module ternary_ripple_inc
  import ternary_pkg::*;
#(
  parameter int N_TRITS = 3
) (
  input  logic [2*N_TRITS-1:0] count,
  input  trit_t                inc,
  output logic [2*N_TRITS-1:0] sum,
  output logic                 carry_out
);

  logic [N_TRITS-1:0] w_carry;

  genvar k;
  generate
    for (k = 0; k < N_TRITS; k++) begin : g_stage
      trit_t w_addend;
      if (k == 0) begin : g_first
        assign w_addend = inc;
      end else begin : g_rest
        // Carry between trits is only ever 0 or 1.
        assign w_addend = {1'b0, w_carry[k-1]};
      end

      trit_half_adder u_ha (
        .a     (count[2*k +: 2]),
        .b     (w_addend),
        .sum   (sum[2*k +: 2]),
        .carry (w_carry[k])
      );
    end
  endgenerate

  assign carry_out = w_carry[N_TRITS-1];

endmodule
`default_nettype wire

// File: rtl/trit_half_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trit_half_adder                                                  |
// | Adds two trits: sum = (a+b) mod 3, carry = (a+b) div 3.          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module trit_half_adder
  import ternary_pkg::*;
(
  input  trit_t a,
  input  trit_t b,
  output trit_t sum,
  output logic  carry
);

  logic [2:0] w_total;
  logic [2:0] w_wrapped;

  assign w_total   = {1'b0, a} + {1'b0, b};
  assign w_wrapped = w_total - 3'd3;

  always_comb begin
    sum   = w_total[1:0];
    carry = 1'b0;
    if (w_total >= 3'd3) begin
      sum   = w_wrapped[1:0];
      carry = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ternary_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ternary_accumulator                                              |
// | N-trit accumulator with load, wrap/saturate and error pulses.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module ternary_accumulator
  import ternary_pkg::*;
#(
  parameter int N_TRITS  = 3,
  parameter int SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           inc,
  input  logic                 load,
  input  logic [2*N_TRITS-1:0] load_val,
  output logic [2*N_TRITS-1:0] count,
  output logic                 ovf,
  output logic                 err,
  output logic                 at_max
);

  localparam logic [2*N_TRITS-1:0] c_all_two = {N_TRITS{TRIT_2}};

  logic [2*N_TRITS-1:0] r_count;
  logic                 r_ovf;
  logic                 r_err;

  logic [2*N_TRITS-1:0] w_sum;
  logic                 w_carry;
  logic                 w_load_legal;
  logic [2*N_TRITS-1:0] w_count_nxt;
  logic                 w_ovf_nxt;
  logic                 w_err_nxt;

  ternary_ripple_inc #(
    .N_TRITS (N_TRITS)
  ) u_ripple (
    .count     (r_count),
    .inc       (inc),
    .sum       (w_sum),
    .carry_out (w_carry)
  );

  always_comb begin
    w_load_legal = 1'b1;
    for (int k = 0; k < N_TRITS; k++) begin
      if (!trit_is_legal(load_val[2*k +: 2])) w_load_legal = 1'b0;
    end
  end

  // Priority below reset: load > accumulate > hold.
  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (load) begin
      if (w_load_legal) w_count_nxt = load_val;
      else              w_err_nxt   = 1'b1;
    end else if (en) begin
      if (!trit_is_legal(inc)) begin
        w_err_nxt = 1'b1;
      end else begin
        w_ovf_nxt   = w_carry;
        w_count_nxt = (w_carry && (SATURATE != 0)) ? c_all_two : w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign count  = r_count;
  assign ovf    = r_ovf;
  assign err    = r_err;
  assign at_max = (r_count == c_all_two);

endmodule
`default_nettype wire
